// File: rtl/md5_candidate_generator.sv
// Walks the 32-bit candidate space and presents each value along with the padded MD5 block
// of its 8-char lowercase hex string, using a valid/ready handshake with pause/stop/restart.
module md5_candidate_generator #(
    parameter logic [31:0] OFFSET = 32'h0000_0000,
    parameter logic [31:0] STRIDE = 32'h0000_0001,
    parameter logic [31:0] LIMIT  = 32'hFFFF_FFFF
) (
    input  logic         CLK,
    input  logic         CPU_RESETN,
    input  logic         enable,
    input  logic         restart,
    input  logic         stop,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [31:0]  candidate,
    output logic [511:0] message,
    output logic [31:0]  issued_count,
    output logic         status_paused,
    output logic         status_done,
    output logic         exhausted
);

    localparam int unsigned CAND_W = 32;
    localparam int unsigned MSG_W  = 512;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CAND_W-1:0]   cand_q, cand_d;
    logic [CAND_W-1:0]   count_q, count_d;
    logic                valid_q, valid_d;
    logic                exh_q, exh_d;
    logic                paused_q, done_q;

    logic                xfer_c;
    logic [CAND_W:0]     next_cand_c;
    logic                past_limit_c;
    logic [CAND_W-1:0]   count_inc_c;

    // The 33-bit sum keeps OFFSET/STRIDE overflow visible to the limit compare.
    assign xfer_c       = valid_q && out_ready;
    assign next_cand_c  = {1'b0, cand_q} + {1'b0, STRIDE};
    assign past_limit_c = next_cand_c > {1'b0, LIMIT};
    assign count_inc_c  = (count_q == {CAND_W{1'b1}}) ? count_q : count_q + CAND_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        count_d = count_q;
        valid_d = valid_q;
        exh_d   = exh_q;

        if (restart) begin
            state_d = ST_IDLE;
            cand_d  = OFFSET;
            count_d = '0;
            valid_d = 1'b0;
            exh_d   = 1'b0;
        end else if (stop) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            exh_d   = 1'b0;
            if (xfer_c) begin
                count_d = count_inc_c;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (enable) begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer_c) begin
                        count_d = count_inc_c;
                        if (past_limit_c) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            exh_d   = 1'b1;
                        end else begin
                            cand_d = next_cand_c[CAND_W-1:0];
                            if (!enable) begin
                                state_d = ST_PAUSED;
                                valid_d = 1'b0;
                            end
                        end
                    end else if (!enable && !valid_q) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q  <= ST_IDLE;
            cand_q   <= OFFSET;
            count_q  <= '0;
            valid_q  <= 1'b0;
            exh_q    <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            exh_q    <= exh_d;
            paused_q <= (state_d == ST_PAUSED);
            done_q   <= (state_d == ST_DONE);
        end
    end

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Char k of the hex string is nibble 7-k; four chars per word, char 0 in the low byte.
    always_comb begin
        message = '0;
        for (int k = 0; k < 8; k++) begin
            message[(k / 4) * WORD_W + (k % 4) * 8 +: 8] = hex_char(cand_q[(7 - k) * 4 +: 4]);
        end
        message[2 * WORD_W +: WORD_W]  = 32'h0000_0080;
        message[14 * WORD_W +: WORD_W] = 32'h0000_0040;
        message[MSG_W-1 -: WORD_W]     = '0;
    end

    assign out_valid     = valid_q;
    assign candidate     = cand_q;
    assign issued_count  = count_q;
    assign status_paused = paused_q;
    assign status_done   = done_q;
    assign exhausted     = exh_q;

endmodule

// File: doc/md5_candidate_generator.md
Name: md5_candidate_generator

Overview:
- Upstream feeder of the MD5 accelerator driver.
- Walks the 32-bit candidate space and emits each candidate in two forms: the raw 32-bit value and the fully padded 512-bit MD5 message block of its 8-character lowercase ASCII hex string.
- Drives the hash pipelines through a valid/ready handshake, honours the enable switch as pause/resume, and stops on exhaustion or on a stop request from the comparator.

Parameters:
- OFFSET, 32'h00000000: first candidate issued after reset or restart.
- STRIDE, 32'h00000001: increment between candidates. Lets N generators interleave: OFFSET=i, STRIDE=N.
- LIMIT, 32'hFFFFFFFF: highest candidate that may be issued (inclusive).

Ports:
- CLK, input, 1: system clock, rising edge.
- CPU_RESETN, input, 1: reset, asynchronous, active-low.
- enable, input, 1: run when high, pause when low (already synchronised upstream).
- restart, input, 1: synchronous pulse; reloads OFFSET and returns to IDLE.
- stop, input, 1: synchronous pulse from the comparator on match; forces DONE.
- out_ready, input, 1: downstream pipeline accepts the current candidate.
- out_valid, output, 1: candidate and message are valid.
- candidate, output, 32: current candidate value.
- message, output, 512: padded MD5 block. Word Mi sits at bits [32i+31:32i].
- issued_count, output, 32: number of completed handshakes since reset/restart.
- status_paused, output, 1: high in PAUSED.
- status_done, output, 1: high in DONE.
- exhausted, output, 1: high in DONE when entry was caused by passing LIMIT.

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - state=IDLE, candidate=OFFSET, out_valid=0, issued_count=0, status_*=0, exhausted=0.
  - Release is synchronous to CLK.
- message is a pure combinational function of the candidate register:
  - Hex string is nibble 7 first. Digits 0-9 map to 0x30-0x39; a-f map to 0x61-0x66.
  - M0 = chars 0..3, little-endian (char 0 in bits [7:0]). M1 = chars 4..7, same packing.
  - M2 = 32'h00000080. M14 = 32'h00000040 (bit length 64). M15 = 0. All other words = 0.
- Handshake:
  - A transfer occurs on an edge where out_valid && out_ready.
  - While out_valid=1 and no transfer occurs, candidate/message hold stable. out_valid never drops without a transfer, except on stop, restart or reset.
- States:
  - IDLE: out_valid=0. enable=1 sampled at an edge moves to RUN, with out_valid=1 after that same edge.
  - RUN, on a transfer:
    - issued_count += 1.
    - next = candidate + STRIDE, computed in 33 bits.
    - If next > LIMIT: go to DONE with exhausted=1 and out_valid=0.
    - Otherwise candidate = next and out_valid stays 1, giving one candidate per cycle under continuous ready.
  - RUN, enable=0: go to PAUSED once !out_valid || transfer on that edge. Until then, remain in RUN with the current candidate held.
    - When the pending transfer completes, candidate advances (or exhaustion is checked) exactly as for any transfer.
    - PAUSED is then entered with out_valid=0.
  - PAUSED: status_paused=1, out_valid=0, candidate holds the next unissued value. enable=1 returns to RUN with out_valid=1 after that edge. No skip, no duplicate.
  - DONE: out_valid=0, status_done=1. Only restart or reset leaves DONE.
- stop in any state (other than reset):
  - Next state DONE, out_valid=0, exhausted=0.
  - candidate and issued_count freeze; a transfer on the same edge still counts.
- restart has priority over stop and enable:
  - Next state IDLE, candidate=OFFSET, issued_count=0, flags cleared, out_valid=0.
- Wrap-around: candidate never wraps. The 33-bit compare catches OFFSET/STRIDE combinations that overflow 32 bits.
- issued_count saturates at 32'hFFFFFFFF.

Test Plan:
- Defaults, reset then enable=1, out_ready=1 -> candidate 0,1,2,3 on consecutive cycles.
  - At candidate 32'h00000200: M0=32'h30303030, M1=32'h30303230, M2=32'h00000080, M14=32'h00000040.
- candidate 32'h0000abcd -> M0=32'h30303030, M1=32'h64636261. Also check 32'hf1d3ff84 hex-string packing word by word.
- Backpressure: out_ready=0 for 3 cycles mid-run -> out_valid stays 1, candidate/message unchanged, issued_count unchanged.
  - On release: exactly one increment per transfer.
- Pause: drop enable while out_valid=1 and out_ready=0 -> valid held until accepted, then PAUSED with status_paused=1.
  - Re-enable -> next candidate = last accepted + STRIDE. Scoreboard shows no gap or repeat.
- OFFSET=1, STRIDE=2, LIMIT=5 -> issues 1,3,5, then status_done=1, exhausted=1, out_valid=0, issued_count=3.
  - Repeat with OFFSET=32'hFFFFFFFE, STRIDE=4 -> one candidate, then exhausted.
- stop mid-run -> DONE with exhausted=0. restart -> IDLE, candidate=OFFSET, count=0.
  - Assert CPU_RESETN low between clock edges -> outputs reach reset values immediately, without waiting for CLK.
